// File: rtl/mult_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_accumulator_if
//  Brief    : Sample-in / window-result-out bundle for mult_accumulator.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_accumulator_if #(
    parameter int ACC_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        convtypeD;
    logic [18:0]       mul1;
    logic [8:0]        mul2;
    logic [6:0]        mul3;
    logic [6:0]        mul4;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc1;
    logic [ACC_W-1:0]  acc2;
    logic [ACC_W-1:0]  acc3;
    logic [ACC_W-1:0]  acc4;
    logic [1:0]        out_convtype;
    logic [3:0]        ovf;

    modport master (
        output in_valid, convtypeD, mul1, mul2, mul3, mul4, out_ready,
        input  in_ready, out_valid, acc1, acc2, acc3, acc4, out_convtype, ovf
    );

    modport slave (
        input  in_valid, convtypeD, mul1, mul2, mul3, mul4, out_ready,
        output in_ready, out_valid, acc1, acc2, acc3, acc4, out_convtype, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_accumulator
//  Brief    : Per-lane accumulation of partial products over a KLEN-sample
//             window, result handed off with valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
    parameter int KLEN  = 9,
    parameter int ACC_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clr,
    mult_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0]       c_KLEN_M1 = 8'(KLEN - 1);
    localparam bit               c_KLEN_1  = (KLEN == 1);
    localparam logic [ACC_W-1:0] c_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_MIN     = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_count;
    logic [1:0]       r_conv;
    logic [ACC_W-1:0] r_acc [4];
    logic [3:0]       r_ovf;

    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_take;
    logic             w_last;
    logic [1:0]       w_conv;
    logic [3:0]       w_en;
    logic [3:0]       w_lane_of;
    logic [ACC_W-1:0] w_mul_ext [4];
    logic [ACC_W-1:0] w_nxt [4];

    assign w_out_valid = (r_state == S_DONE);
    assign w_in_ready  = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    // Any accept outside ACCUM opens a new window (including the drain cycle).
    assign w_start     = w_accept && (r_state != S_ACCUM);
    assign w_take      = w_accept && !(w_start && (bus.convtypeD == 2'b00));
    assign w_conv      = w_start ? bus.convtypeD : r_conv;
    assign w_last      = w_take && (w_start ? c_KLEN_1 : (r_count == c_KLEN_M1));

    assign w_en[0] = (w_conv != 2'b00);
    assign w_en[1] = (w_conv == 2'b01) || (w_conv == 2'b10);
    assign w_en[2] = (w_conv == 2'b01);
    assign w_en[3] = (w_conv == 2'b01);

    assign w_mul_ext[0] = w_en[0] ? ACC_W'($signed(bus.mul1)) : '0;
    assign w_mul_ext[1] = w_en[1] ? ACC_W'($signed(bus.mul2)) : '0;
    assign w_mul_ext[2] = w_en[2] ? ACC_W'($signed(bus.mul3)) : '0;
    assign w_mul_ext[3] = w_en[3] ? ACC_W'($signed(bus.mul4)) : '0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [ACC_W:0] w_sum;
            // One guard bit: overflow when the guard disagrees with the MSB.
            assign w_sum = {r_acc[gi][ACC_W-1], r_acc[gi]} +
                           {w_mul_ext[gi][ACC_W-1], w_mul_ext[gi]};
            assign w_lane_of[gi] = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            assign w_nxt[gi] = (w_lane_of[gi] && SAT) ?
                               (w_sum[ACC_W] ? c_MIN : c_MAX) : w_sum[ACC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = w_last ? S_DONE : S_ACCUM;
            S_ACCUM: if (w_take && w_last) w_state_nxt = S_DONE;
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = w_take ? (w_last ? S_DONE : S_ACCUM) : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_conv  <= 2'b00;
            r_ovf   <= '0;
            for (int i = 0; i < 4; i++) r_acc[i] <= '0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= '0;
            for (int i = 0; i < 4; i++) r_acc[i] <= '0;
        end else if (w_take) begin
            if (w_start) begin
                r_conv <= bus.convtypeD;
                r_ovf  <= '0;
                for (int i = 0; i < 4; i++) r_acc[i] <= w_mul_ext[i];
            end else begin
                r_ovf  <= r_ovf | w_lane_of;
                for (int i = 0; i < 4; i++) r_acc[i] <= w_nxt[i];
            end
            r_count <= w_last ? 8'd0 : (w_start ? 8'd1 : 8'(r_count + 8'd1));
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.acc1         = r_acc[0];
    assign bus.acc2         = r_acc[1];
    assign bus.acc3         = r_acc[2];
    assign bus.acc4         = r_acc[3];
    assign bus.out_convtype = r_conv;
    assign bus.ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_accumulator
//  Brief    : Scoreboard bench; three DUT configurations share one stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

    localparam int KLEN = 9;

    typedef struct packed {
        logic [3:0][63:0] acc;
        logic [3:0]       ovf;
        logic [1:0]       conv;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  conv = 2'b00;
    logic [18:0] m1 = '0;
    logic [8:0]  m2 = '0;
    logic [6:0]  m3 = '0;
    logic [6:0]  m4 = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_accumulator_if #(.ACC_W(32)) b32 ();
    mult_accumulator_if #(.ACC_W(19)) bs ();
    mult_accumulator_if #(.ACC_W(19)) bw ();

    assign b32.in_valid = in_valid;  assign bs.in_valid = in_valid;  assign bw.in_valid = in_valid;
    assign b32.out_ready = out_ready; assign bs.out_ready = out_ready; assign bw.out_ready = out_ready;
    assign b32.convtypeD = conv;     assign bs.convtypeD = conv;     assign bw.convtypeD = conv;
    assign b32.mul1 = m1;            assign bs.mul1 = m1;            assign bw.mul1 = m1;
    assign b32.mul2 = m2;            assign bs.mul2 = m2;            assign bw.mul2 = m2;
    assign b32.mul3 = m3;            assign bs.mul3 = m3;            assign bw.mul3 = m3;
    assign b32.mul4 = m4;            assign bs.mul4 = m4;            assign bw.mul4 = m4;

    mult_accumulator #(.KLEN(KLEN), .ACC_W(32), .SAT(1'b1)) u_dut32 (
        .clk(clk), .rst(rst), .clr(clr), .bus(b32.slave));
    mult_accumulator #(.KLEN(KLEN), .ACC_W(19), .SAT(1'b1)) u_dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .bus(bs.slave));
    mult_accumulator #(.KLEN(KLEN), .ACC_W(19), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst(rst), .clr(clr), .bus(bw.slave));

    // Reference model: index 0 = 32-bit sat, 1 = 19-bit sat, 2 = 19-bit wrap.
    int         c_w   [3] = '{32, 19, 19};
    bit         c_sat [3] = '{1'b1, 1'b1, 1'b0};
    longint     m_acc [3][4];
    logic [3:0] m_ovf [3];
    logic [1:0] m_conv = 2'b00;
    bit         m_open = 1'b0;
    bit         m_done = 1'b0;
    int         m_count = 0;
    res_t       q0[$];
    res_t       q1[$];
    res_t       q2[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t e, input longint a1, input longint a2,
                           input longint a3, input longint a4, input logic [3:0] ov,
                           input logic [1:0] cv);
        check({tag, "_acc1"}, a1, e.acc[0]);
        check({tag, "_acc2"}, a2, e.acc[1]);
        check({tag, "_acc3"}, a3, e.acc[2]);
        check({tag, "_acc4"}, a4, e.acc[3]);
        check({tag, "_ovf"},  ov, e.ovf);
        check({tag, "_conv"}, cv, e.conv);
    endtask

    function automatic longint lane_in(input int l);
        case (l)
            0:       return longint'($signed(m1));
            1:       return longint'($signed(m2));
            2:       return longint'($signed(m3));
            default: return longint'($signed(m4));
        endcase
    endfunction

    function automatic bit lane_en(input int l, input logic [1:0] c);
        if (l == 0) return c != 2'b00;
        if (l == 1) return (c == 2'b01) || (c == 2'b10);
        return c == 2'b01;
    endfunction

    task automatic model_clear(input bit full);
        m_open = 1'b0; m_done = 1'b0; m_count = 0;
        if (full) m_conv = 2'b00;
        for (int k = 0; k < 3; k++) begin
            m_ovf[k] = '0;
            for (int l = 0; l < 4; l++) m_acc[k][l] = 0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Check outputs at the falling edge, then advance the model past the next rising edge.
    task automatic step();
        bit     rdy;
        longint hi, lo, v, span;
        res_t   r;
        @(negedge clk);
        rdy = !m_done || out_ready;
        if (!rst) begin
            check("in_ready", b32.in_ready, rdy);
            check("out_valid32", b32.out_valid, m_done);
            check("out_valid19", bw.out_valid, m_done);
            if (m_done && q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
                cmp_res("r32", q0[0], longint'($signed(b32.acc1)), longint'($signed(b32.acc2)),
                        longint'($signed(b32.acc3)), longint'($signed(b32.acc4)), b32.ovf, b32.out_convtype);
                cmp_res("rsat", q1[0], longint'($signed(bs.acc1)), longint'($signed(bs.acc2)),
                        longint'($signed(bs.acc3)), longint'($signed(bs.acc4)), bs.ovf, bs.out_convtype);
                cmp_res("rwrap", q2[0], longint'($signed(bw.acc1)), longint'($signed(bw.acc2)),
                        longint'($signed(bw.acc3)), longint'($signed(bw.acc4)), bw.ovf, bw.out_convtype);
                if (out_ready) begin
                    void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
                end
            end
        end
        if (rst) begin
            model_clear(1'b1);
        end else if (clr) begin
            model_clear(1'b0);
        end else begin
            if (m_done && out_ready) m_done = 1'b0;
            if (in_valid && rdy && !(!m_open && conv == 2'b00)) begin
                if (!m_open) begin
                    m_conv = conv; m_count = 0;
                    for (int k = 0; k < 3; k++) begin
                        m_ovf[k] = '0;
                        for (int l = 0; l < 4; l++) m_acc[k][l] = 0;
                    end
                end
                m_count++;
                for (int k = 0; k < 3; k++) begin
                    hi = (longint'(1) << (c_w[k] - 1)) - 1;
                    lo = -hi - 1;
                    span = longint'(1) << c_w[k];
                    for (int l = 0; l < 4; l++) begin
                        v = m_acc[k][l] + (lane_en(l, m_conv) ? lane_in(l) : 0);
                        if (v > hi || v < lo) begin
                            m_ovf[k][l] = 1'b1;
                            if (c_sat[k]) begin
                                v = (v > hi) ? hi : lo;
                            end else begin
                                v = (v - lo) % span;
                                if (v < 0) v += span;
                                v += lo;
                            end
                        end
                        m_acc[k][l] = v;
                    end
                end
                if (m_count == KLEN) begin
                    m_done = 1'b1; m_open = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        for (int l = 0; l < 4; l++) r.acc[l] = 64'(m_acc[k][l]);
                        r.ovf = m_ovf[k]; r.conv = m_conv;
                        if (k == 0) q0.push_back(r);
                        else if (k == 1) q1.push_back(r);
                        else q2.push_back(r);
                    end
                end else begin
                    m_open = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [1:0] c, input logic [18:0] a, input logic [8:0] b,
                          input logic [6:0] cc, input logic [6:0] d);
        in_valid = 1'b1; conv = c; m1 = a; m2 = b; m3 = cc; m4 = d;
        step();
    endtask

    task automatic rnd(input logic [1:0] c);
        sample(c, 19'($urandom), 9'($urandom), 7'($urandom), 7'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; m1 = 19'($urandom); conv = 2'($urandom);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        check("rst_in_ready", b32.in_ready, 1'b1);
        check("rst_out_valid", b32.out_valid, 1'b0);
        check("rst_acc1", b32.acc1, 32'd0);
        check("rst_acc4", b32.acc4, 32'd0);
        check("rst_ovf", b32.ovf, 4'd0);
        check("rst_conv", b32.out_convtype, 2'b00);
        rst = 1'b0;

        // CONV_8: only lane 1 accumulates even with noise on the other lanes
        out_ready = 1'b1;
        for (int i = 0; i < KLEN; i++)
            sample(2'b11, 19'h7FF01, 9'($urandom), 7'($urandom), 7'($urandom));
        check("t2_out_valid", b32.out_valid, 1'b1);
        check("t2_acc1", b32.acc1, 32'hFFFFF709);
        check("t2_acc2", b32.acc2, 32'd0);
        check("t2_conv", b32.out_convtype, 2'b11);
        idle(1);

        for (int i = 0; i < KLEN; i++) sample(2'b01, 19'd4, 9'h1FD, 7'h7A, 7'd5);
        check("t3_acc1", b32.acc1, 32'd36);
        check("t3_acc2", b32.acc2, 32'hFFFFFFE5);
        check("t3_acc3", b32.acc3, 32'hFFFFFFCA);
        check("t3_acc4", b32.acc4, 32'd45);
        check("t3_ovf", b32.ovf, 4'd0);
        idle(1);

        for (int i = 0; i < KLEN; i++) sample(2'b11, 19'h3FFFF, 9'd0, 7'd0, 7'd0);
        check("t4_sat_acc1", bs.acc1, 19'h3FFFF);
        check("t4_sat_ovf0", bs.ovf[0], 1'b1);
        check("t4_wrap_acc1", bw.acc1, 19'h3FFF7);
        check("t4_wrap_ovf0", bw.ovf[0], 1'b1);
        check("t4_acc1_32", b32.acc1, 32'd2359287);
        check("t4_ovf_32", b32.ovf, 4'd0);
        idle(1);

        // Backpressure, then drain overlapping with the first sample of the next window
        out_ready = 1'b0;
        for (int i = 0; i < KLEN; i++) rnd(2'b10);
        for (int i = 0; i < 3; i++) rnd(2'b01);
        check("t5_stall_ready", b32.in_ready, 1'b0);
        out_ready = 1'b1;
        rnd(2'b01);
        for (int i = 0; i < KLEN - 1; i++) rnd(2'b01);
        check("t5_next_valid", b32.out_valid, 1'b1);
        check("t5_next_conv", b32.out_convtype, 2'b01);
        idle(1);

        for (int i = 0; i < 4; i++) rnd(2'b11);
        clr = 1'b1;
        rnd(2'b01);
        clr = 1'b0;
        check("t6_clr_valid", b32.out_valid, 1'b0);
        check("t6_clr_acc1", b32.acc1, 32'd0);
        for (int i = 0; i < KLEN; i++) rnd(2'b11);
        idle(1);

        for (int i = 0; i < 4; i++) rnd(2'b10);
        for (int i = 0; i < 5; i++) rnd(2'b01);
        check("t6_conv_latched", b32.out_convtype, 2'b10);
        check("t6_acc3_masked", b32.acc3, 32'd0);
        idle(1);

        // Invalid precision at window start is swallowed without opening a window
        rnd(2'b00);
        for (int i = 0; i < KLEN; i++) rnd(2'b01);
        idle(1);

        // clr discards a result waiting on backpressure
        out_ready = 1'b0;
        for (int i = 0; i < KLEN; i++) rnd(2'b01);
        idle(1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        out_ready = 1'b1;
        check("t7_clr_done", b32.out_valid, 1'b0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
